// File: rtl/grid_loader_pkg.sv
// grid_loader_pkg: shared definitions for the grid loader.
//   The start-of-frame byte, default grid geometry and default load
//   timeout are held as macros (overridable from the command line) and
//   exposed as package localparams. The package also defines the loader
//   state type and a start-of-frame test helper.
`ifndef SOF
`define SOF 8'hA5
`endif
`ifndef GRID_W
`define GRID_W 16
`endif
`ifndef GRID_H
`define GRID_H 16
`endif
`ifndef LOAD_TIMEOUT
`define LOAD_TIMEOUT 50000
`endif

package grid_loader_pkg;

    localparam logic [7:0] SOF_BYTE    = `SOF;
    localparam int         DEF_GRID_W  = `GRID_W;
    localparam int         DEF_GRID_H  = `GRID_H;
    localparam int         DEF_TIMEOUT = `LOAD_TIMEOUT;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } state_t;

    function automatic logic is_sof(input logic [7:0] b);
        return b == SOF_BYTE;
    endfunction

endpackage

// File: rtl/grid_loader_idle.sv
// idle_timer: clearable, enabled up-counter with a terminal-count flag.
//   clk  in   clock
//   rst  in   asynchronous active-low reset
//   en   in   count enable (counter holds when low)
//   clr  in   synchronous clear, has priority over counting
//   tc   out  high when the next enabled cycle brings the count to LIMIT
module idle_timer
    import grid_loader_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_p1;

    // Stage p1: idle-cycle count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_p1 <= '0;
        end else if (clr) begin
            cnt_p1 <= '0;
        end else if (en && (cnt_p1 != CW'(LIMIT))) begin
            cnt_p1 <= cnt_p1 + 1'b1;
        end
    end

    // Flagged one cycle early so the owner's transition lands on the edge
    // where the count would reach LIMIT.
    assign tc = en && (cnt_p1 == CW'(LIMIT - 1));

endmodule

// File: rtl/grid_loader.sv
// grid_loader: detects a start-of-frame byte on the receive stream, tells
// the control unit a frame is pending, waits for its acknowledge, then
// writes NBYTES packed cell bytes into the grid memory. A sticky load_done
// marks a committed grid; stalled frames abort with a frame_err pulse.
//   clk, rst       clock, asynchronous active-low reset
//   en             global enable: freezes state/counters, blocks handshakes
//   in_data/valid  received byte stream; in_ready accepts it
//   receive_data   one-cycle acknowledge from the control unit
//   data_incoming  frame pending or loading
//   load_done      sticky grid-complete flag
//   mem_we/addr/wdata  registered grid memory write port
//   frame_err      one-cycle timeout abort pulse
module grid_loader
    import grid_loader_pkg::*;
#(
    parameter int GRID_W  = DEF_GRID_W,
    parameter int GRID_H  = DEF_GRID_H,
    parameter int NBYTES  = GRID_W * GRID_H / 8,
    parameter int AW      = $clog2(NBYTES),
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          receive_data,
    output logic          data_incoming,
    output logic          load_done,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          frame_err
);

    state_t        state, state_n;
    logic          accept;
    logic          write_en;
    logic          last_byte;
    logic          timeout;
    logic          tmr_en;
    logic          tmr_clr;
    logic          err_set;
    logic [AW-1:0] cnt_p1;
    logic          vld_p1;
    logic [AW-1:0] addr_p1;
    logic [7:0]    wdata_p1;
    logic          err_p1;
    logic          done_p1;

    assign in_ready      = en && ((state == ST_IDLE) || (state == ST_LOAD) ||
                                  (state == ST_DONE));
    assign data_incoming = (state == ST_ARM) || (state == ST_LOAD) ||
                           (state == ST_FLUSH);
    assign accept        = in_valid && in_ready;
    assign write_en      = accept && (state == ST_LOAD);
    assign last_byte     = (cnt_p1 == AW'(NBYTES - 1));

    // The timer restarts on every accepted byte and every state change.
    assign tmr_en  = en && ((state == ST_ARM) || (state == ST_LOAD));
    assign tmr_clr = accept || (state_n != state);

    idle_timer #(
        .LIMIT(TIMEOUT)
    ) u_idle_timer (
        .clk(clk),
        .rst(rst),
        .en (tmr_en),
        .clr(tmr_clr),
        .tc (timeout)
    );

    always_comb begin
        state_n = state;
        err_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && is_sof(in_data)) state_n = ST_ARM;
            end
            ST_ARM: begin
                if (en && receive_data) begin
                    state_n = ST_LOAD;
                end else if (timeout) begin
                    state_n = ST_IDLE;
                    err_set = 1'b1;
                end
            end
            ST_LOAD: begin
                // An accepted byte takes precedence over a coincident timeout.
                if (accept) begin
                    if (last_byte) state_n = ST_FLUSH;
                end else if (timeout) begin
                    state_n = ST_IDLE;
                    err_set = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (en) state_n = ST_DONE;
            end
            ST_DONE: begin
                if (accept && is_sof(in_data)) state_n = ST_ARM;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Stage p1: control state, byte counter, status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt_p1  <= '0;
            done_p1 <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            state  <= state_n;
            err_p1 <= err_set;
            if ((state == ST_ARM) && (state_n == ST_LOAD)) begin
                cnt_p1 <= '0;
            end else if (write_en && !last_byte) begin
                cnt_p1 <= cnt_p1 + 1'b1;
            end
            if ((state == ST_FLUSH) && (state_n == ST_DONE)) begin
                done_p1 <= 1'b1;
            end else if (state_n == ST_ARM) begin
                done_p1 <= 1'b0;
            end
        end
    end

    // Stage p1: memory write register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= write_en;
            if (write_en) begin
                addr_p1  <= cnt_p1;
                wdata_p1 <= in_data;
            end
        end
    end

    assign mem_we    = vld_p1;
    assign mem_addr  = addr_p1;
    assign mem_wdata = wdata_p1;
    assign frame_err = err_p1;
    assign load_done = done_p1;

endmodule

// File: tb/tb_grid_loader.sv
// tb_grid_loader: directed bench for grid_loader with a 16x16 grid (32
// payload bytes) and a 100-cycle load timeout.
module tb_grid_loader;

    localparam logic [7:0] SOF = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       receive_data = 1'b0;
    logic       in_ready;
    logic       data_incoming;
    logic       load_done;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int we_count = 0;
    int err_count = 0;
    logic [7:0] model [32];

    grid_loader #(
        .TIMEOUT(100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .receive_data (receive_data),
        .data_incoming(data_incoming),
        .load_done    (load_done),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // Capture the write port and error pulses once per cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            model[mem_addr] = mem_wdata;
            we_count++;
        end
        if (frame_err === 1'b1) err_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte, wait for in_ready, complete the handshake on the
    // next rising edge and return at the following falling edge.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        #1;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("send_wait", 32'(n), 32'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic ack();
        receive_data = 1'b1;
        @(negedge clk);
        receive_data = 1'b0;
    endtask

    task automatic check_mem(input string tag, input logic [7:0] base, input int sof_pos);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("%s_mem%0d", tag, k), 32'(model[k]),
                  (k == sof_pos) ? 32'(SOF) : 32'(base + 8'(k)));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},   32'(in_ready),      32'(1));
        check({tag, "_di"},    32'(data_incoming), 32'(0));
        check({tag, "_ld"},    32'(load_done),     32'(0));
        check({tag, "_we"},    32'(mem_we),        32'(0));
        check({tag, "_addr"},  32'(mem_addr),      32'(0));
        check({tag, "_wdata"}, 32'(mem_wdata),     32'(0));
        check({tag, "_err"},   32'(frame_err),     32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wc;
        int ec;
        int n;
        int rdy_seen;

        // Reset state
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Acknowledge and junk bytes in IDLE are ignored
        ack();
        check("idle_ack_di", 32'(data_incoming), 32'(0));
        send(8'h11);
        send(8'h22);
        #1;
        check("junk_di", 32'(data_incoming), 32'(0));
        check("junk_we", 32'(we_count), 32'(0));

        // SOF, acknowledge three cycles later, full 32-byte frame
        send(SOF);
        check("sof_di", 32'(data_incoming), 32'(1));
        check("sof_ld", 32'(load_done), 32'(0));
        check("arm_rdy", 32'(in_ready), 32'(0));
        repeat (2) @(negedge clk);
        check("arm_rdy2", 32'(in_ready), 32'(0));
        ack();
        #1;
        check("load_rdy", 32'(in_ready), 32'(1));
        check("load_di", 32'(data_incoming), 32'(1));
        for (int k = 0; k < 32; k++) send(8'(k));
        check("flush_rdy", 32'(in_ready), 32'(0));
        check("flush_di", 32'(data_incoming), 32'(1));
        check("flush_ld", 32'(load_done), 32'(0));
        check("flush_we", 32'(mem_we), 32'(1));
        check("flush_addr", 32'(mem_addr), 32'(31));
        check("flush_wdata", 32'(mem_wdata), 32'(8'h1F));
        @(negedge clk);
        #1;
        check("done_ld", 32'(load_done), 32'(1));
        check("done_di", 32'(data_incoming), 32'(0));
        check("done_rdy", 32'(in_ready), 32'(1));
        check("done_we", 32'(mem_we), 32'(0));
        check("frame1_count", 32'(we_count), 32'(32));
        check_mem("f1", 8'h00, -1);

        // Acknowledge in DONE is ignored; SOF reloads with A5 as data
        ack();
        #1;
        check("done_ack_ld", 32'(load_done), 32'(1));
        check("done_ack_di", 32'(data_incoming), 32'(0));
        wc = we_count;
        send(SOF);
        check("reload_ld", 32'(load_done), 32'(0));
        check("reload_di", 32'(data_incoming), 32'(1));
        ack();
        for (int k = 0; k < 32; k++) send((k == 5) ? SOF : 8'h40 + 8'(k));
        @(negedge clk);
        #1;
        check("reload_done", 32'(load_done), 32'(1));
        check("reload_count", 32'(we_count - wc), 32'(32));
        check_mem("f2", 8'h40, 5);

        // en low mid-LOAD freezes handshakes, counter and timer
        send(SOF);
        ack();
        for (int k = 0; k < 10; k++) send(8'h80 + 8'(k));
        repeat (80) @(negedge clk);
        #1;
        wc = we_count;
        ec = err_count;
        en = 1'b0;
        in_data = 8'h8A;
        in_valid = 1'b1;
        rdy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (in_ready === 1'b1) rdy_seen++;
        end
        #1;
        check("freeze_we", 32'(we_count - wc), 32'(0));
        check("freeze_rdy", 32'(rdy_seen), 32'(0));
        check("freeze_err", 32'(err_count - ec), 32'(0));
        check("freeze_di", 32'(data_incoming), 32'(1));
        en = 1'b1;
        in_valid = 1'b0;
        for (int k = 10; k < 32; k++) send(8'h80 + 8'(k));
        @(negedge clk);
        #1;
        check("resume_done", 32'(load_done), 32'(1));
        check("resume_err", 32'(err_count - ec), 32'(0));
        check("resume_count", 32'(we_count - wc), 32'(22));
        check_mem("f3", 8'h80, -1);

        // Stall after 10 payload bytes
        send(SOF);
        ack();
        for (int k = 0; k < 10; k++) send(8'hC0 + 8'(k));
        n = 0;
        while (frame_err !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("stall_cycles", 32'(n), 32'(100));
        check("stall_ld", 32'(load_done), 32'(0));
        check("stall_di", 32'(data_incoming), 32'(0));
        check("stall_rdy", 32'(in_ready), 32'(1));
        @(negedge clk);
        check("stall_pulse", 32'(frame_err), 32'(0));

        // SOF with no acknowledge
        send(SOF);
        n = 0;
        rdy_seen = 0;
        while (frame_err !== 1'b1 && n < 300) begin
            if (in_ready === 1'b1) rdy_seen++;
            @(negedge clk);
            n++;
        end
        check("noack_cycles", 32'(n), 32'(100));
        check("noack_rdy", 32'(rdy_seen), 32'(0));
        check("noack_di", 32'(data_incoming), 32'(0));
        @(negedge clk);
        check("noack_pulse", 32'(frame_err), 32'(0));

        // Reset asserted mid-LOAD
        send(SOF);
        ack();
        for (int k = 0; k < 5; k++) send(8'hE0 + 8'(k));
        check("prerst_we", 32'(mem_we), 32'(1));
        check("prerst_wdata", 32'(mem_wdata), 32'(8'hE4));
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("postrst_di", 32'(data_incoming), 32'(0));
        check("postrst_rdy", 32'(in_ready), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grid_loader.md
# grid_loader

Upstream feeder for the compute control unit: accepts a byte stream from the serial receiver, detects a start-of-frame byte, and tells the control unit a frame is arriving. It waits for the control unit's acknowledge pulse, then writes the packed cell bytes into the grid memory. It raises a sticky load-complete flag once the whole grid is committed. Frames that stall mid-transfer are aborted with an error pulse.

## Interface
Parameters:
- GRID_W, 16, cells per row
- GRID_H, 16, rows
- NBYTES, GRID_W*GRID_H/8, payload bytes per frame; 8 cells per byte, LSB is the lowest cell index
- AW, clog2(NBYTES), memory address width
- TIMEOUT, 50000, maximum enabled cycles between accepted bytes in ARM or LOAD

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  global enable; when low, state and counters freeze, in_ready=0, mem_we=0
- in_data  in  8  received byte
- in_valid  in  1  byte available
- in_ready  out  1  byte accepted when in_valid&&in_ready on a rising edge
- receive_data  in  1  one-cycle acknowledge pulse from the control unit
- data_incoming  out  1  high while a frame is pending or loading
- load_done  out  1  sticky: grid holds a complete frame
- mem_we  out  1  grid memory write strobe
- mem_addr  out  AW  byte address, 0..NBYTES-1
- mem_wdata  out  8  byte to write
- frame_err  out  1  one-cycle pulse on timeout abort

## Operation
States:
- IDLE: in_ready=1. A byte equal to `SOF (8'hA5) -> ARM. Other bytes are consumed and discarded.
- ARM: data_incoming=1, in_ready=0, load_done cleared. receive_data=1 -> LOAD with byte counter=0. Timeout -> IDLE with frame_err.
- LOAD: data_incoming=1, in_ready=1. Each accepted byte is written at address=counter and counter increments. A byte equal to `SOF is plain data (no escaping). When byte NBYTES-1 is accepted -> FLUSH. Timeout -> IDLE with frame_err; load_done stays 0.
- FLUSH: one cycle, in_ready=0, data_incoming=1. Always -> DONE.
- DONE: load_done=1, data_incoming=0, in_ready=1. A `SOF byte -> ARM, which drops load_done. Other bytes are discarded.

Other rules:
- Timer: counts enabled cycles in ARM/LOAD; cleared on every state change and on every accepted byte. Abort when the count reaches TIMEOUT.
- receive_data outside ARM is ignored.
- Reset mid-frame: returns to IDLE and load_done=0. Memory contents are undefined-but-unchanged.
- Reset values: in_ready=1 (qualified by en), data_incoming=0, load_done=0, mem_we=0, mem_addr=0, mem_wdata=0, frame_err=0.

## Timing
- in_ready and data_incoming are combinational from state and en. All other outputs are registered.
- Accepted byte at edge N: mem_we, mem_addr and mem_wdata are valid for exactly cycle N+1.
- Last byte accepted at edge N: FLUSH occupies cycle N+1 (coincident with the last mem_we). load_done=1 and data_incoming=0 from cycle N+2.
- SOF accepted at edge N: data_incoming=1 and load_done=0 from cycle N+1. LOAD is entered the cycle after receive_data is sampled high.
- Simultaneous timeout and accepted byte in LOAD: the byte wins and the timer clears.
- Counter width AW; it never wraps, because the FLUSH transition occurs at NBYTES-1.
- frame_err is high for exactly one cycle, the cycle after the abort edge.

## Structure
- def.vh (shared) holds `SOF, `GRID_W, `GRID_H and `LOAD_TIMEOUT. Parameter defaults take their values from these.
- One sub-module, idle_timer: a clearable enabled up-counter with a terminal-count flag.
- The FSM, byte counter and write register stay in grid_loader.

## Test plan
- Full frame: A5 then 32 bytes 00..1F, receive_data pulsed 3 cycles after SOF -> 32 mem_we, with addr k receiving data k. load_done rises 2 cycles after the last handshake; data_incoming then falls.
- Pre-SOF junk: 11, 22 in IDLE -> no mem_we, data_incoming stays 0. A5 -> data_incoming=1 next cycle.
- Stall: TIMEOUT=100, 10 payload bytes then silence -> frame_err pulse 100 cycles after the 10th byte, state IDLE, load_done=0.
- No acknowledge: A5 with receive_data never pulsed -> in_ready=0 throughout ARM, frame_err after 100 cycles.
- Reload: in DONE send A5 -> load_done drops next cycle. A payload containing A5 at byte 5 -> written to addr 5 as data.
- en low for 20 cycles mid-LOAD with in_valid=1 -> no handshakes, counter and timer frozen, transfer resumes intact.
- Reset asserted mid-LOAD -> all outputs return to reset values immediately.
